// File: rtl/card_dealer.sv
// Card dealer for a two-player flip-and-collect card game.
// Keeps per-player face-down counts, the face-up slot per player and the
// table pile. After each accepted flip, further flips are locked out for a
// fixed number of cycles.
module card_dealer #(
  parameter int DECK_PER_PLAYER = 28,
  parameter int LOCK_CYC        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       flip,
  input  logic       collect,
  input  logic       collect_who,
  input  logic [4:0] rnd,
  output logic [4:0] card1,
  output logic [4:0] card2,
  output logic       turn,
  output logic [5:0] cnt1,
  output logic [5:0] cnt2,
  output logic [5:0] pile,
  output logic       flip_done,
  output logic       game_over,
  output logic       winner
);

  localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [5:0] DECK = 6'(DECK_PER_PLAYER);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_LOCK, S_OVER} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lock_q, lock_d;
  logic [4:0]      card1_q, card1_d;
  logic [4:0]      card2_q, card2_d;
  logic            turn_q, turn_d;
  logic [5:0]      cnt1_q, cnt1_d;
  logic [5:0]      cnt2_q, cnt2_d;
  logic [5:0]      pile_q, pile_d;
  logic            flip_done_q, flip_done_d;
  logic            game_over_q, game_over_d;
  logic            winner_q, winner_d;

  logic [5:0]      cur_cnt;
  logic [2:0]      num_mod;
  logic [4:0]      new_card;

  // Card value from the random source: colour as-is, number folded into 1..5
  always_comb begin
    num_mod  = (rnd[2:0] >= 3'd5) ? (rnd[2:0] - 3'd5) : rnd[2:0];
    new_card = {rnd[4:3], num_mod + 3'd1};
    cur_cnt  = turn_q ? cnt2_q : cnt1_q;
  end

  // Next-state logic; a collect outranks any flip in the same cycle
  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    card1_d     = card1_q;
    card2_d     = card2_q;
    turn_d      = turn_q;
    cnt1_d      = cnt1_q;
    cnt2_d      = cnt2_q;
    pile_d      = pile_q;
    flip_done_d = 1'b0;
    game_over_d = game_over_q;
    winner_d    = winner_q;

    case (state_q)
      S_IDLE: begin
        cnt1_d      = DECK;
        cnt2_d      = DECK;
        pile_d      = '0;
        card1_d     = '0;
        card2_d     = '0;
        turn_d      = 1'b0;
        game_over_d = 1'b0;
        winner_d    = 1'b0;
        if (start) state_d = S_PLAY;
      end

      S_PLAY, S_LOCK: begin
        if (collect && (pile_q != '0)) begin
          if (collect_who) cnt2_d = cnt2_q + pile_q;
          else             cnt1_d = cnt1_q + pile_q;
          pile_d  = '0;
          card1_d = '0;
          card2_d = '0;
          turn_d  = collect_who;
          state_d = S_PLAY;
        end else if (state_q == S_PLAY) begin
          if (cur_cnt == '0) begin
            state_d     = S_OVER;
            game_over_d = 1'b1;
            winner_d    = ~turn_q;
          end else if (flip) begin
            if (turn_q) begin
              card2_d = new_card;
              cnt2_d  = cnt2_q - 6'd1;
            end else begin
              card1_d = new_card;
              cnt1_d  = cnt1_q - 6'd1;
            end
            pile_d      = pile_q + 6'd1;
            turn_d      = ~turn_q;
            flip_done_d = 1'b1;
            lock_d      = LW'(LOCK_CYC - 1);
            state_d     = S_LOCK;
          end
        end else begin
          if (lock_q == '0) state_d = S_PLAY;
          else              lock_d  = lock_q - 1'b1;
        end
      end

      S_OVER: begin
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lock_q      <= '0;
      card1_q     <= '0;
      card2_q     <= '0;
      turn_q      <= 1'b0;
      cnt1_q      <= DECK;
      cnt2_q      <= DECK;
      pile_q      <= '0;
      flip_done_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      card1_q     <= card1_d;
      card2_q     <= card2_d;
      turn_q      <= turn_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      pile_q      <= pile_d;
      flip_done_q <= flip_done_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign card1     = card1_q;
  assign card2     = card2_q;
  assign turn      = turn_q;
  assign cnt1      = cnt1_q;
  assign cnt2      = cnt2_q;
  assign pile      = pile_q;
  assign flip_done = flip_done_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer with hand-computed expected values.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       flip;
  logic       collect;
  logic       collect_who;
  logic [4:0] rnd;
  logic [4:0] card1, card2;
  logic       turn;
  logic [5:0] cnt1, cnt2, pile;
  logic       flip_done, game_over, winner;

  int n_cmp = 0;
  int n_bad = 0;

  card_dealer #(.DECK_PER_PLAYER(28), .LOCK_CYC(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .flip        (flip),
    .collect     (collect),
    .collect_who (collect_who),
    .rnd         (rnd),
    .card1       (card1),
    .card2       (card2),
    .turn        (turn),
    .cnt1        (cnt1),
    .cnt2        (cnt2),
    .pile        (pile),
    .flip_done   (flip_done),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flip(input logic [4:0] r);
    flip = 1'b1;
    rnd  = r;
    tick();
    flip = 1'b0;
  endtask

  int e1, e2;
  logic t;
  int guard;

  initial begin
    rst = 1'b0; start = 1'b0; flip = 1'b0; collect = 1'b0;
    collect_who = 1'b0; rnd = '0;
    tick(); tick();
    check("rst_cnt1", cnt1, 28);
    check("rst_cnt2", cnt2, 28);
    check("rst_pile", pile, 0);
    check("rst_card1", card1, 0);
    check("rst_card2", card2, 0);
    check("rst_turn", turn, 0);
    check("rst_fdone", flip_done, 0);
    check("rst_gover", game_over, 0);
    check("rst_winner", winner, 0);

    // IDLE ignores flip and collect
    rst = 1'b1;
    flip = 1'b1; collect = 1'b1; rnd = 5'b11_111;
    tick();
    flip = 1'b0; collect = 1'b0;
    check("idle_cnt1", cnt1, 28);
    check("idle_card1", card1, 0);
    check("idle_fdone", flip_done, 0);

    start = 1'b1; tick(); start = 1'b0;

    // First flip: rnd 10_110 -> colour 2, number 6%5+1 = 2
    do_flip(5'b10_110);
    check("f1_card1", card1, 5'b10_010);
    check("f1_cnt1", cnt1, 27);
    check("f1_pile", pile, 1);
    check("f1_turn", turn, 1);
    check("f1_fdone", flip_done, 1);
    tick();
    check("f1_fdone_pulse", flip_done, 0);
    // Flip two cycles after the first lands inside LOCK
    do_flip(5'b01_111);
    check("lock_cnt2", cnt2, 28);
    check("lock_pile", pile, 1);
    check("lock_card2", card2, 0);
    tick(); tick();
    // Five edges after the first flip: back in PLAY
    do_flip(5'b01_111);
    check("f2_card2", card2, 5'b01_011);
    check("f2_cnt2", cnt2, 27);
    check("f2_turn", turn, 0);
    check("f2_pile", pile, 2);
    repeat (4) tick();
    do_flip(5'b00_000);
    check("f3_card1", card1, 5'b00_001);
    check("f3_cnt1", cnt1, 26);
    check("f3_pile", pile, 3);

    // Collect during LOCK to player 2
    collect = 1'b1; collect_who = 1'b1; tick(); collect = 1'b0;
    check("col_pile", pile, 0);
    check("col_cnt2", cnt2, 30);
    check("col_cnt1", cnt1, 26);
    check("col_card1", card1, 0);
    check("col_card2", card2, 0);
    check("col_turn", turn, 1);
    // Collect aborted LOCK: immediate flip by player 2 is accepted
    do_flip(5'b11_100);
    check("abort_card2", card2, 5'b11_101);
    check("abort_cnt2", cnt2, 29);
    check("abort_pile", pile, 1);
    check("abort_turn", turn, 0);
    repeat (4) tick();

    // Flip and collect together: only the collect applies
    flip = 1'b1; collect = 1'b1; collect_who = 1'b0; rnd = 5'b01_001;
    tick();
    flip = 1'b0; collect = 1'b0;
    check("both_cnt1", cnt1, 27);
    check("both_cnt2", cnt2, 29);
    check("both_pile", pile, 0);
    check("both_card1", card1, 0);
    check("both_fdone", flip_done, 0);
    check("both_sum", cnt1 + cnt2 + pile, 56);

    // Collect with empty pile does nothing
    collect = 1'b1; collect_who = 1'b1; tick(); collect = 1'b0;
    check("col0_turn", turn, 0);
    check("col0_cnt2", cnt2, 29);

    // Play out until player 1 runs dry
    e1 = 27; e2 = 29; t = 1'b0; guard = 0;
    while (guard < 80 && ((t == 1'b0) ? e1 : e2) > 0) begin
      do_flip(5'b00_000);
      if (t == 1'b0) e1--; else e2--;
      t = ~t;
      repeat (4) tick();
      guard++;
    end
    check("go_guard", guard, 54);
    check("go_not_yet", game_over, 0);
    tick();
    check("go_level", game_over, 1);
    check("go_winner", winner, 1);
    check("go_cnt1", cnt1, 0);
    check("go_cnt2", cnt2, 2);
    check("go_pile", pile, 54);
    do_flip(5'b00_000);
    collect = 1'b1; collect_who = 1'b0; tick(); collect = 1'b0;
    check("over_cnt2", cnt2, 2);
    check("over_pile", pile, 54);
    check("over_level", game_over, 1);

    // Mid-game reset during LOCK with pile 5
    rst = 1'b0; tick(); rst = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_flip(5'b00_010);
      if (i < 4) repeat (4) tick();
    end
    check("pre_rst_pile", pile, 5);
    rst = 1'b0; tick(); rst = 1'b1;
    check("mrst_pile", pile, 0);
    check("mrst_cnt1", cnt1, 28);
    check("mrst_cnt2", cnt2, 28);
    check("mrst_card1", card1, 0);
    check("mrst_gover", game_over, 0);
    start = 1'b1; tick(); start = 1'b0;
    do_flip(5'b01_100);
    check("restart_cnt1", cnt1, 27);
    check("restart_card1", card1, 5'b01_101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 Parameter DECK_PER_PLAYER, default 28: cards each player holds at game start.
REQ-002 Parameter LOCK_CYC, default 4: cycles flips are ignored after an accepted flip.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 start  input  1  one-cycle pulse; begins a game from IDLE.
REQ-006 flip  input  1  one-cycle pulse from the keypad path; the current player flips a card.
REQ-007 collect  input  1  one-cycle pulse; the bell resolved correctly and the winner takes the pile.
REQ-008 collect_who  input  1  collect winner: 0 = player 1, 1 = player 2; valid only with collect.
REQ-009 rnd  input  5  current rand_gen value; sampled only on an accepted flip.
REQ-010 card1, card2  output  5  face-up card per player: [4:3] colour 0..3, [2:0] number 1..5, number 0 = empty slot.
REQ-011 turn  output  1  player to flip next: 0 = player 1, 1 = player 2.
REQ-012 cnt1, cnt2  output  6  face-down cards held per player.
REQ-013 pile  output  6  cards currently face-up on the table since the last collect.
REQ-014 flip_done  output  1  one-cycle pulse in the cycle after an accepted flip.
REQ-015 game_over  output  1  level; high in OVER.
REQ-016 winner  output  1  in OVER, the player who still holds cards (0 = player 1); 0 otherwise.

Function
REQ-017 FSM states: IDLE, PLAY, LOCK, OVER; reset enters IDLE.
REQ-018 IDLE: load cnt1 = cnt2 = DECK_PER_PLAYER, pile = 0, slots empty, turn = 0; start -> PLAY; flip and collect are ignored.
REQ-019 PLAY, flip with the current player's count > 0: accept the flip.
- Write the new card into the current player's slot; the colour is rnd[4:3], the number is (rnd[2:0] mod 5) + 1.
- Decrement that player's count and increment pile.
- Toggle turn, pulse flip_done next cycle, then go to LOCK.
REQ-020 LOCK lasts exactly LOCK_CYC cycles, then returns to PLAY; flips during LOCK are dropped; collect is honoured.
REQ-021 Collect in PLAY or LOCK with pile > 0:
- Add pile to the winner's count; set pile = 0 and empty both slots.
- Set turn = collect_who and go to PLAY, which aborts LOCK.
REQ-022 Collect with pile = 0 produces no state change.
REQ-023 Collect and flip in the same cycle: the collect takes effect and the flip is dropped.
REQ-024 In PLAY, if the player whose turn it is has count 0, go to OVER in the next cycle; winner = the other player.
REQ-025 OVER holds all outputs until reset; start, flip and collect are ignored.
REQ-026 cnt1 + cnt2 + pile = 2*DECK_PER_PLAYER at all times outside reset; no counter wraps.
REQ-027 Collect adds with a 6-bit result; the maximum sum, 2*DECK_PER_PLAYER = 56, fits.
REQ-028 Outputs are registered; the slot, count, pile and turn updates are visible in the cycle after the accepted input.

Reset
REQ-029 While rst = 0 at a clock edge, the block sets state = IDLE.
REQ-030 Reset also sets card1 = card2 = 0, turn = 0, cnt1 = cnt2 = DECK_PER_PLAYER, pile = 0, flip_done = 0, game_over = 0 and winner = 0.
REQ-031 Reset asserted mid-game (PLAY, LOCK or OVER) aborts the game and discards the pile.
REQ-032 With rst = 1, the first start pulse is honoured.

Verification
REQ-033 Reset, start, flip with rnd = 5'b10_110 -> next cycle card1 = 5'b10_010, cnt1 = 27, pile = 1, turn = 1, flip_done = 1.
REQ-034 A second flip 2 cycles after the first (inside LOCK) -> ignored, cnt2 = 28; a flip after LOCK_CYC cycles -> card2 is written and cnt2 = 27.
REQ-035 After 3 accepted flips, collect with collect_who = 1 -> pile = 0, cnt2 = 27 + 3 = 30, both slots = 0, turn = 1.
REQ-036 Flip and collect in the same cycle -> only the collect applies; counts are conserved (sum = 56).
REQ-037 Player 1 flips the last card and player 2 collects nothing; on player 1's turn with cnt1 = 0 -> game_over = 1 and winner = 1; a later flip has no effect.
REQ-038 rst = 0 for one cycle during LOCK with pile = 5 -> next cycle state IDLE, pile = 0, cnt1 = cnt2 = 28.
